// File: rtl/cmd_sequencer_if.sv
// Host/CPU-side bundle for the command sequencer: host push port, CPU error input,
// and the issued command plus status back to host and CPU.
interface cmd_sequencer_if #(
    parameter int unsigned CMD_W = 7,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [CMD_W-1:0]  in_cmd;
    logic              in_ready;
    logic              cpu_error;
    logic              clear_err;
    logic [CMD_W-1:0]  cmd_out;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  issued_cnt;
    logic              idle;
    logic              err_sticky;
    logic [CMD_W-1:0]  err_cmd;

    modport slave (
        input  in_valid, in_cmd, cpu_error, clear_err,
        output in_ready, cmd_out, level, issued_cnt, idle, err_sticky, err_cmd
    );

    modport master (
        output in_valid, in_cmd, cpu_error, clear_err,
        input  in_ready, cmd_out, level, issued_cnt, idle, err_sticky, err_cmd
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Buffers host commands and issues each one to the CPU for a single cycle followed by
// a fixed NOP gap; cpu_error is checked during the gap and can halt issue until cleared.
module cmd_sequencer #(
    parameter int unsigned      CMD_W         = 7,
    parameter int unsigned      DEPTH         = 4,
    parameter int unsigned      NOP_CYCLES    = 2,
    parameter logic [CMD_W-1:0] NOP_CMD       = 7'b0000100,
    parameter int unsigned      CNT_W         = 8,
    parameter bit               HALT_ON_ERROR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    cmd_sequencer_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned GAP_W = (NOP_CYCLES > 1) ? $clog2(NOP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_HALT} state_e;

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [CMD_W-1:0]   last_q, last_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [CMD_W-1:0]   err_cmd_q, err_cmd_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0]   mem_q [DEPTH];

    logic               in_ready_c;
    logic               push_c;
    logic               pop_c;
    logic [CMD_W-1:0]   head_c;

    assign in_ready_c = (level_q < LVL_W'(DEPTH));
    assign push_c     = bus.in_valid && in_ready_c;
    assign head_c     = mem_q[rd_ptr_q];

    // Issue sequencing: IDLE -> ISSUE (one cycle) -> GAP (NOP_CYCLES) -> ISSUE/IDLE, or HALT on error
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        last_d    = last_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_cmd_d = err_cmd_q;
        pop_c     = 1'b0;

        if (bus.clear_err) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cmd_d = NOP_CMD;
                if (level_q != '0) begin
                    pop_c   = 1'b1;
                    cmd_d   = head_c;
                    last_d  = head_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_d   = NOP_CMD;
                gap_d   = GAP_W'(NOP_CYCLES - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                cmd_d = NOP_CMD;
                // Error is assigned after clear_err so a coincident error wins
                if (bus.cpu_error) begin
                    err_d     = 1'b1;
                    err_cmd_d = last_q;
                end
                if (bus.cpu_error && HALT_ON_ERROR) begin
                    state_d = S_HALT;
                end else if (gap_q == '0) begin
                    if (level_q != '0) begin
                        pop_c   = 1'b1;
                        cmd_d   = head_c;
                        last_d  = head_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_HALT: begin
                cmd_d = NOP_CMD;
                if (bus.clear_err) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cmd_d   = NOP_CMD;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= NOP_CMD;
            last_q    <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_cmd_q <= '0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_cmd_q <= err_cmd_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.in_cmd;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.cmd_out    = cmd_q;
    assign bus.level      = level_q;
    assign bus.issued_cnt = cnt_q;
    assign bus.idle       = (state_q == S_IDLE) && (level_q == '0);
    assign bus.err_sticky = err_q;
    assign bus.err_cmd    = err_cmd_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: expected issues are queued at stimulus time and
// a negedge monitor checks command value and issue spacing for a halting and a flag-only DUT.
module tb_cmd_sequencer;
    localparam logic [6:0] NOP = 7'b0000100;

    typedef struct {
        logic [6:0] cmd;
        int         delta;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_a = 0;
    int   last_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_sequencer_if #(.CMD_W(7), .DEPTH(4), .CNT_W(8)) ifa ();
    cmd_sequencer_if #(.CMD_W(7), .DEPTH(4), .CNT_W(8)) ifb ();

    cmd_sequencer #(.CMD_W(7), .DEPTH(4), .NOP_CYCLES(2), .NOP_CMD(7'b0000100),
                    .CNT_W(8), .HALT_ON_ERROR(1'b1))
        u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    cmd_sequencer #(.CMD_W(7), .DEPTH(4), .NOP_CYCLES(2), .NOP_CMD(7'b0000100),
                    .CNT_W(8), .HALT_ON_ERROR(1'b0))
        u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_a(input logic [6:0] c, input int d);
        exp_t e;
        e.cmd = c; e.delta = d;
        qa.push_back(e);
    endtask

    task automatic exp_b(input logic [6:0] c, input int d);
        exp_t e;
        e.cmd = c; e.delta = d;
        qb.push_back(e);
    endtask

    task automatic push_a(input logic [6:0] c);
        ifa.in_valid = 1'b1; ifa.in_cmd = c;
        @(negedge clk);
        ifa.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [6:0] c);
        ifb.in_valid = 1'b1; ifb.in_cmd = c;
        @(negedge clk);
        ifb.in_valid = 1'b0;
    endtask

    task automatic wait_cmd_a(input logic [6:0] c);
        int n = 0;
        while (ifa.cmd_out !== c && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("a_wait_timeout", 32'(ifa.cmd_out), 32'(c));
    endtask

    task automatic wait_cmd_b(input logic [6:0] c);
        int n = 0;
        while (ifb.cmd_out !== c && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("b_wait_timeout", 32'(ifb.cmd_out), 32'(c));
    endtask

    task automatic err_pulse_a();
        @(negedge clk); ifa.cpu_error = 1'b1;
        @(negedge clk); ifa.cpu_error = 1'b0;
    endtask

    task automatic clear_a();
        ifa.clear_err = 1'b1;
        @(negedge clk); ifa.clear_err = 1'b0;
    endtask

    // Monitor: every non-NOP cycle on cmd_out is one issue that must match the queue head
    always @(negedge clk) begin
        if (rst === 1'b1 && ifa.cmd_out !== NOP) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_issue", 32'(ifa.cmd_out), 32'(NOP));
            end else begin
                ea = qa.pop_front();
                chk("a_cmd", 32'(ifa.cmd_out), 32'(ea.cmd));
                if (ea.delta != 0) chk("a_spacing", 32'(cyc - last_a), 32'(ea.delta));
            end
            last_a = cyc;
        end
        if (rst === 1'b1 && ifb.cmd_out !== NOP) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_issue", 32'(ifb.cmd_out), 32'(NOP));
            end else begin
                eb = qb.pop_front();
                chk("b_cmd", 32'(ifb.cmd_out), 32'(eb.cmd));
                if (eb.delta != 0) chk("b_spacing", 32'(cyc - last_b), 32'(eb.delta));
            end
            last_b = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] burst [4];
        burst[0] = 7'b0101000; burst[1] = 7'b0110001;
        burst[2] = 7'b1000010; burst[3] = 7'b1011011;

        rst = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_cmd = '0; ifa.cpu_error = 1'b0; ifa.clear_err = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_cmd = '0; ifb.cpu_error = 1'b0; ifb.clear_err = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cmd_out",    32'(ifa.cmd_out), 32'(NOP));
        chk("rst_level",      32'(ifa.level), 0);
        chk("rst_in_ready",   32'(ifa.in_ready), 1);
        chk("rst_idle",       32'(ifa.idle), 1);
        chk("rst_err_sticky", 32'(ifa.err_sticky), 0);
        chk("rst_issued",     32'(ifa.issued_cnt), 0);
        chk("rst_err_cmd",    32'(ifa.err_cmd), 0);
        rst = 1'b1;
        @(negedge clk);

        // Two commands, each followed by two NOPs
        exp_a(7'b0001000, 0); push_a(7'b0001000);
        exp_a(7'b0000110, 3); push_a(7'b0000110);
        repeat (10) @(negedge clk);
        chk("seq_issued", 32'(ifa.issued_cnt), 2);
        chk("seq_idle",   32'(ifa.idle), 1);
        chk("seq_level",  32'(ifa.level), 0);

        // cpu_error while idle is ignored
        ifa.cpu_error = 1'b1; @(negedge clk); ifa.cpu_error = 1'b0;
        chk("idle_err_ignored", 32'(ifa.err_sticky), 0);

        // Error in first gap cycle halts with the next command held
        exp_a(7'b1110011, 0); push_a(7'b1110011);
        push_a(7'b0000101);
        wait_cmd_a(7'b1110011);
        err_pulse_a();
        chk("halt_err_sticky", 32'(ifa.err_sticky), 1);
        chk("halt_err_cmd",    32'(ifa.err_cmd), 32'(7'b1110011));
        chk("halt_idle",       32'(ifa.idle), 0);
        repeat (6) @(negedge clk);
        chk("halt_level_held", 32'(ifa.level), 1);
        chk("halt_issued",     32'(ifa.issued_cnt), 3);
        exp_a(7'b0000101, 0);
        clear_a();
        chk("clear_err_sticky", 32'(ifa.err_sticky), 0);
        repeat (6) @(negedge clk);
        chk("resume_issued", 32'(ifa.issued_cnt), 4);
        chk("resume_idle",   32'(ifa.idle), 1);

        // Fill the FIFO while halted; the fifth push is dropped
        exp_a(7'b0011001, 0); push_a(7'b0011001);
        wait_cmd_a(7'b0011001);
        err_pulse_a();
        chk("halt2_err_cmd", 32'(ifa.err_cmd), 32'(7'b0011001));
        for (int i = 0; i < 4; i++) begin
            chk("fill_in_ready", 32'(ifa.in_ready), 1);
            exp_a(burst[i], (i == 0) ? 0 : 3);
            push_a(burst[i]);
        end
        chk("full_level",    32'(ifa.level), 4);
        chk("full_in_ready", 32'(ifa.in_ready), 0);
        push_a(7'b1111111);
        chk("full_drop_level", 32'(ifa.level), 4);
        clear_a();
        repeat (16) @(negedge clk);
        chk("drain_issued", 32'(ifa.issued_cnt), 9);
        chk("drain_idle",   32'(ifa.idle), 1);

        // Flag-only instance: error does not stop the next issue
        exp_b(7'b1110011, 0); push_b(7'b1110011);
        exp_b(7'b0000101, 3); push_b(7'b0000101);
        wait_cmd_b(7'b1110011);
        @(negedge clk); ifb.cpu_error = 1'b1;
        @(negedge clk); ifb.cpu_error = 1'b0;
        chk("b_err_sticky", 32'(ifb.err_sticky), 1);
        chk("b_err_cmd",    32'(ifb.err_cmd), 32'(7'b1110011));
        repeat (6) @(negedge clk);
        chk("b_issued", 32'(ifb.issued_cnt), 2);
        ifb.clear_err = 1'b1; @(negedge clk); ifb.clear_err = 1'b0;
        chk("b_clear_outside_halt", 32'(ifb.err_sticky), 0);

        // Coincident clear_err and error: error wins
        exp_b(7'b0100110, 0); push_b(7'b0100110);
        wait_cmd_b(7'b0100110);
        @(negedge clk); ifb.cpu_error = 1'b1; ifb.clear_err = 1'b1;
        @(negedge clk); ifb.cpu_error = 1'b0; ifb.clear_err = 1'b0;
        chk("b_err_beats_clear", 32'(ifb.err_sticky), 1);
        chk("b_err_cmd2",        32'(ifb.err_cmd), 32'(7'b0100110));
        repeat (6) @(negedge clk);

        // Asynchronous reset while a command is on cmd_out
        exp_a(7'b0111010, 0); push_a(7'b0111010);
        push_a(7'b0001001);
        wait_cmd_a(7'b0111010);
        #2 rst = 1'b0;
        #1;
        chk("arst_cmd_out", 32'(ifa.cmd_out), 32'(NOP));
        chk("arst_level",   32'(ifa.level), 0);
        chk("arst_issued",  32'(ifa.issued_cnt), 0);
        @(negedge clk); rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_issued", 32'(ifa.issued_cnt), 0);
        chk("post_rst_idle",   32'(ifa.idle), 1);
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
